// File: rtl/fir_mac_sequencer.sv
// FIR front end: buffers the last TAPS samples and sequences taps into an external signed MAC.
// Latency: sample handshake to y_valid_o is TAPS+3 cycles; accepts one sample every TAPS+4 cycles.
// Backpressure: s_ready_o is low from a sample handshake until the result handshake completes.
module fir_mac_sequencer #(
    parameter int TAPS  = 8,
    parameter int A_W   = 24,
    parameter int B_W   = 18,
    parameter int RES_W = 43
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic signed [A_W-1:0]    s_data_i,
    input  logic                     coef_we_i,
    input  logic [$clog2(TAPS)-1:0]  coef_addr_i,
    input  logic signed [B_W-1:0]    coef_data_i,
    output logic signed [A_W-1:0]    mac_a_o,
    output logic signed [B_W-1:0]    mac_b_o,
    output logic                     mac_clear_o,
    input  logic signed [RES_W-1:0]  mac_res_i,
    output logic                     y_valid_o,
    input  logic                     y_ready_i,
    output logic signed [RES_W-1:0]  y_data_o
);

    localparam int PTR_W = $clog2(TAPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_OUT
    } state_t;

    state_t                 state_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       base_q;
    logic [PTR_W-1:0]       tap_q;
    logic [PTR_W-1:0]       tap_nxt;
    logic [PTR_W-1:0]       rd_idx;
    logic                   wait2_q;
    logic signed [A_W-1:0]  sbuf_q [TAPS];
    logic signed [B_W-1:0]  coef_q [TAPS];
    logic                   s_hs;
    logic                   coef_wr;

    assign s_hs    = s_valid_i & s_ready_o;
    assign coef_wr = coef_we_i & (state_q == S_IDLE);
    assign tap_nxt = tap_q + PTR_W'(1);
    // Newest sample sits at base; older taps walk backwards, wrapping naturally at power-of-two depth.
    assign rd_idx  = base_q - tap_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TAPS; i++) begin
                sbuf_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (s_hs) begin
                sbuf_q[wr_ptr_q] <= s_data_i;
            end
            if (coef_wr) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            tap_q       <= '0;
            wait2_q     <= 1'b0;
            s_ready_o   <= 1'b0;
            mac_a_o     <= '0;
            mac_b_o     <= '0;
            mac_clear_o <= 1'b0;
            y_valid_o   <= 1'b0;
            y_data_o    <= '0;
        end else begin
            mac_clear_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    s_ready_o <= 1'b1;
                    if (s_hs) begin
                        s_ready_o <= 1'b0;
                        base_q    <= wr_ptr_q;
                        wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
                        tap_q     <= '0;
                        // Tap 0 bypasses both arrays so a same-cycle sample or c[0] write is seen.
                        mac_a_o   <= s_data_i;
                        mac_b_o   <= (coef_wr && coef_addr_i == '0) ? coef_data_i : coef_q[0];
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // The MAC registers its product, so the clear lands one cycle after tap 0.
                    if (tap_q == '0) begin
                        mac_clear_o <= 1'b1;
                    end
                    if (tap_q == PTR_W'(TAPS - 1)) begin
                        mac_a_o <= '0;
                        mac_b_o <= '0;
                        wait2_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        mac_a_o <= sbuf_q[rd_idx];
                        mac_b_o <= coef_q[tap_nxt];
                        tap_q   <= tap_nxt;
                    end
                end
                S_WAIT: begin
                    wait2_q <= 1'b1;
                    if (wait2_q) begin
                        y_data_o  <= mac_res_i;
                        y_valid_o <= 1'b1;
                        state_q   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (y_ready_i) begin
                        y_valid_o <= 1'b0;
                        s_ready_o <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer with a two-stage signed MAC model (registered product, then accumulate).
// Expected results are queued at issue time and checked by a monitor on each y handshake.
module tb_fir_mac_sequencer;

    localparam int TAPS  = 8;
    localparam int A_W   = 24;
    localparam int B_W   = 18;
    localparam int RES_W = 43;
    localparam int PW    = $clog2(TAPS);

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic signed [A_W-1:0]   s_data_i;
    logic                    coef_we_i;
    logic [PW-1:0]           coef_addr_i;
    logic signed [B_W-1:0]   coef_data_i;
    logic signed [A_W-1:0]   mac_a_o;
    logic signed [B_W-1:0]   mac_b_o;
    logic                    mac_clear_o;
    logic signed [RES_W-1:0] mac_res_i;
    logic                    y_valid_o;
    logic                    y_ready_i;
    logic signed [RES_W-1:0] y_data_o;

    logic signed [A_W+B_W-1:0] prod_q;
    logic signed [RES_W-1:0]   acc_q;
    logic signed [RES_W-1:0]   exp_q [$];
    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fir_mac_sequencer #(.TAPS(TAPS), .A_W(A_W), .B_W(B_W), .RES_W(RES_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .coef_we_i   (coef_we_i),
        .coef_addr_i (coef_addr_i),
        .coef_data_i (coef_data_i),
        .mac_a_o     (mac_a_o),
        .mac_b_o     (mac_b_o),
        .mac_clear_o (mac_clear_o),
        .mac_res_i   (mac_res_i),
        .y_valid_o   (y_valid_o),
        .y_ready_i   (y_ready_i),
        .y_data_o    (y_data_o)
    );

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= mac_a_o * mac_b_o;
            acc_q  <= mac_clear_o ? RES_W'(prod_q) : acc_q + RES_W'(prod_q);
        end
    end
    assign mac_res_i = acc_q;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && y_valid_o && y_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL y_unexpected: got result %0d, expected no result", y_data_o);
            end else begin
                check("y_data", y_data_o, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_coef(input int k, input int v);
        coef_we_i   = 1'b1;
        coef_addr_i = PW'(k);
        coef_data_i = B_W'(v);
        tick();
        coef_we_i   = 1'b0;
    endtask

    // Returns in cycle 1 after the handshake edge.
    task automatic push(input int x, input longint e, input bit has_exp = 1'b1,
                        input bit cw = 1'b0, input int ca = 0, input int cd = 0);
        int n = 0;
        while (!s_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!s_ready_o) check("s_ready_timeout", s_ready_o, 1);
        if (has_exp) exp_q.push_back(RES_W'(e));
        s_valid_i   = 1'b1;
        s_data_i    = A_W'(x);
        coef_we_i   = cw;
        coef_addr_i = PW'(ca);
        coef_data_i = B_W'(cd);
        tick();
        s_valid_i   = 1'b0;
        coef_we_i   = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    task automatic check_clear(input int x, input int c0);
        check("tap0_a", mac_a_o, x);
        check("tap0_b", mac_b_o, c0);
        check("clear_c1", mac_clear_o, 0);
        tick();
        check("clear_c2", mac_clear_o, 1);
        tick();
        check("clear_c3", mac_clear_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_ni = 1'b0; s_valid_i = 1'b0; s_data_i = '0; coef_we_i = 1'b0;
        coef_addr_i = '0; coef_data_i = '0; y_ready_i = 1'b1;
        tick();
        tick();
        check("rst_s_ready", s_ready_o, 0);
        check("rst_mac_a", mac_a_o, 0);
        check("rst_mac_b", mac_b_o, 0);
        check("rst_clear", mac_clear_o, 0);
        check("rst_y_valid", y_valid_o, 0);
        check("rst_y_data", y_data_o, 0);
        rst_ni = 1'b1;
        check("s_ready_pre_edge", s_ready_o, 0);
        tick();
        check("s_ready_post_rst", s_ready_o, 1);

        // Impulse response
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        push(1000, 1000);
        for (int i = 1; i < TAPS; i++) push(0, 1000 * (i + 1));
        push(0, 0);
        wait_drain();

        // Extreme operands and clear alignment
        write_coef(0, -131072);
        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
        push(-8388608, 64'sd1099511627776);
        check_clear(-8388608, -131072);
        push(5, -655360);
        check_clear(5, -131072);
        wait_drain();

        // Flush old history with all-ones taps, then wrap-around
        for (int k = 0; k < TAPS; k++) write_coef(k, 1);
        for (int j = 1; j <= 8; j++) push(0, (j <= 6) ? -8388603 : ((j == 7) ? 5 : 0));
        for (int i = 1; i <= 20; i++) push(i, (i <= 8) ? i * (i + 1) / 2 : 8 * i - 28);
        wait_drain();

        // Back-pressure: result held, held sample refused until after y handshake
        y_ready_i = 1'b0;
        push(100, 219);
        n = 0;
        while (!y_valid_o && n < 50) begin
            tick();
            n++;
        end
        if (!y_valid_o) check("y_valid_timeout", y_valid_o, 1);
        exp_q.push_back(RES_W'(405));
        s_valid_i = 1'b1;
        s_data_i  = A_W'(200);
        for (int i = 0; i < 10; i++) begin
            check("bp_y_data", y_data_o, 219);
            check("bp_y_valid", y_valid_o, 1);
            check("bp_s_ready", s_ready_o, 0);
            tick();
        end
        y_ready_i = 1'b1;
        tick();
        check("s_ready_after_y", s_ready_o, 1);
        tick();
        s_valid_i = 1'b0;
        check("held_accept_tap0", mac_a_o, 200);
        check("held_accept_busy", s_ready_o, 0);
        wait_drain();

        // Coefficient write while busy is dropped; in IDLE it takes effect
        push(10, 400);
        tick();
        coef_we_i   = 1'b1;
        coef_addr_i = PW'(3);
        coef_data_i = B_W'(500);
        tick();
        coef_we_i   = 1'b0;
        push(0, 384);
        wait_drain();
        write_coef(3, 500);
        push(0, 100167);
        push(1, 5341, 1'b1, 1'b1, 0, 2);
        wait_drain();

        // Reset in RUN cycle 4
        push(9, 0, 1'b0);
        tick();
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        check("mid_rst_mac_a", mac_a_o, 0);
        check("mid_rst_mac_b", mac_b_o, 0);
        check("mid_rst_clear", mac_clear_o, 0);
        check("mid_rst_s_ready", s_ready_o, 0);
        check("mid_rst_y_valid", y_valid_o, 0);
        check("mid_rst_y_data", y_data_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("no_y_after_rst", y_valid_o, 0);
        push(7, 0);
        wait_drain();

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
